// File: rtl/vga_if.sv
// VGA timing bundle passed between pixel pipeline stages.
interface vga_if;
  logic [11:0] vcount;
  logic [11:0] hcount;
  logic        vsync;
  logic        hsync;
  logic        vblnk;
  logic        hblnk;
  logic [11:0] rgb;

  // Consumer side: samples timing and background colour.
  modport in (
    input vcount,
    input hcount,
    input vsync,
    input hsync,
    input vblnk,
    input hblnk,
    input rgb
  );

  // Producer side: drives timing and composited colour.
  modport out (
    output vcount,
    output hcount,
    output vsync,
    output hsync,
    output vblnk,
    output hblnk,
    output rgb
  );
endinterface

// File: rtl/draw_sprite.sv
// Sprite overlay stage for the VGA pixel pipeline.
// Overlays a SPRITE_W x SPRITE_H image, upscaled by 2^SCALE_LOG2, at a position latched at frame
// start. The image comes from an external synchronous ROM with ROM_LAT cycles of read latency;
// timing and background travel alongside so everything leaves together ROM_LAT+2 cycles later.
module draw_sprite #(
  parameter int unsigned SPRITE_W       = 64,
  parameter int unsigned SPRITE_H       = 64,
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned ROM_LAT        = 1,
  parameter int unsigned SCALE_LOG2     = 0,
  parameter bit          TRANSPARENT_EN = 1'b1,
  parameter logic [11:0] KEY_COLOR      = 12'hF0F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  input  logic [11:0]       rgb_pixel,
  output logic [ADDR_W-1:0] pixel_addr,
  vga_if.in                 vga_in,
  vga_if.out                vga_out
);

  // On-screen footprint of the scaled image; 13 bits so position + span never wraps.
  localparam logic [12:0] SPAN_X = 13'(SPRITE_W << SCALE_LOG2);
  localparam logic [12:0] SPAN_Y = 13'(SPRITE_H << SCALE_LOG2);

  typedef struct packed {
    logic [11:0] vcount;
    logic [11:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;
  } vga_t;

  typedef struct packed {
    vga_t vga;
    logic hit;
  } stage_t;

  // Frame-latched placement.
  logic [11:0] active_x_q;
  logic [11:0] active_y_q;
  logic        active_en_q;

  // Stage A combinational results.
  logic              frame_start;
  logic [11:0]       cur_x;
  logic [11:0]       cur_y;
  logic              cur_en;
  logic              in_x;
  logic              in_y;
  logic              hit;
  logic [11:0]       dx;
  logic [11:0]       dy;
  logic [11:0]       lx;
  logic [11:0]       ly;
  logic [ADDR_W-1:0] addr_d;
  stage_t            stage_d;

  // Index 0 is stage A; index ROM_LAT lines up with valid ROM data.
  stage_t            pipe_q [0:ROM_LAT];
  logic [ADDR_W-1:0] addr_q;

  // Output stage.
  stage_t tail;
  logic   key_match;
  vga_t   out_d;
  vga_t   out_q;

  // Latch position and enable only at the first pixel of a frame so the image never tears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_x_q  <= '0;
      active_y_q  <= '0;
      active_en_q <= 1'b0;
    end else if (frame_start) begin
      active_x_q  <= xpos;
      active_y_q  <= ypos;
      active_en_q <= en;
    end
  end

  // Stage A: hit test and ROM address for the incoming pixel.
  always_comb begin
    frame_start = (vga_in.vcount == 12'd0) && (vga_in.hcount == 12'd0);
    // The pixel that triggers the latch already uses the values being latched.
    cur_x  = frame_start ? xpos : active_x_q;
    cur_y  = frame_start ? ypos : active_y_q;
    cur_en = frame_start ? en : active_en_q;

    in_x = ({1'b0, vga_in.hcount} >= {1'b0, cur_x}) &&
           ({1'b0, vga_in.hcount} < ({1'b0, cur_x} + SPAN_X));
    in_y = ({1'b0, vga_in.vcount} >= {1'b0, cur_y}) &&
           ({1'b0, vga_in.vcount} < ({1'b0, cur_y} + SPAN_Y));
    hit  = cur_en && in_x && in_y;

    // Offsets are only meaningful on a hit, where they are non-negative and in range.
    dx = vga_in.hcount - cur_x;
    dy = vga_in.vcount - cur_y;
    lx = dx >> SCALE_LOG2;
    ly = dy >> SCALE_LOG2;

    addr_d = hit ? ADDR_W'(32'(ly) * SPRITE_W + 32'(lx)) : '0;

    stage_d.vga.vcount = vga_in.vcount;
    stage_d.vga.hcount = vga_in.hcount;
    stage_d.vga.vsync  = vga_in.vsync;
    stage_d.vga.hsync  = vga_in.hsync;
    stage_d.vga.vblnk  = vga_in.vblnk;
    stage_d.vga.hblnk  = vga_in.hblnk;
    stage_d.vga.rgb    = vga_in.rgb;
    stage_d.hit        = hit;
  end

  // Stage A register plus ROM_LAT wait stages carrying timing, background and hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      for (int i = 0; i <= int'(ROM_LAT); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      addr_q    <= addr_d;
      pipe_q[0] <= stage_d;
      for (int i = 1; i <= int'(ROM_LAT); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Composite: blanking forces black, then opaque image pixels, else background.
  always_comb begin
    tail      = pipe_q[ROM_LAT];
    key_match = TRANSPARENT_EN && (rgb_pixel == KEY_COLOR);
    out_d     = tail.vga;
    if (tail.vga.hblnk || tail.vga.vblnk) begin
      out_d.rgb = 12'h000;
    end else if (tail.hit && !key_match) begin
      out_d.rgb = rgb_pixel;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign pixel_addr     = addr_q;
  assign vga_out.vcount = out_q.vcount;
  assign vga_out.hcount = out_q.hcount;
  assign vga_out.vsync  = out_q.vsync;
  assign vga_out.hsync  = out_q.hsync;
  assign vga_out.vblnk  = out_q.vblnk;
  assign vga_out.hblnk  = out_q.hblnk;
  assign vga_out.rgb    = out_q.rgb;

endmodule
